// File: rtl/midi_uart_rx_fifo.sv
// Serial receiver for the MIDI input pin: 2-flop synchroniser, mid-bit sampling FSM,
// framing/parity/overrun error pulses and a small valid/ready receive FIFO.
//
// state   | meaning
// S_IDLE  | line idle, waiting for a falling edge on the synchronised line
// S_START | timing half a bit, then confirming the start bit is still low
// S_DATA  | sampling DATA_BITS data bits, LSB first
// S_PARITY| sampling the parity bit (only when PARITY != 0)
// S_STOP  | sampling the stop bit and deciding push / error
// S_BREAK | stop bit was low, waiting for the line to return high
module midi_uart_rx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk500kHz,
    input  logic                          rst_n,
    input  logic                          rx_in,
    output logic [DATA_BITS-1:0]          rx_byte,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t               state, state_nxt;
    logic [1:0]           sync_q;
    logic                 s, s_prev;
    logic [CW-1:0]        tmr, tmr_nxt;
    logic                 tc;
    logic [BW-1:0]        bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par_bit, par_bit_nxt;
    logic                 par_ok;
    logic                 push_req, do_push, pop, full;
    logic                 frame_nxt, parity_nxt, overrun_nxt;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        count;
    logic [DATA_BITS-1:0] last_head;

    assign s  = sync_q[1];
    assign tc = (tmr == '0);

    always_comb begin
        if (PARITY == 1)
            par_ok = ~(^shreg ^ par_bit);
        else if (PARITY == 2)
            par_ok = ^shreg ^ par_bit;
        else
            par_ok = 1'b1;
    end

    always_ff @(posedge clk500kHz) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            s_prev     <= 1'b1;
            state      <= S_IDLE;
            tmr        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx_in};
            s_prev     <= s;
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            par_bit    <= par_bit_nxt;
            frame_err  <= frame_nxt;
            parity_err <= parity_nxt;
            overrun    <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tmr_nxt     = tc ? tmr : tmr - CW'(1);
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        par_bit_nxt = par_bit;
        push_req    = 1'b0;
        frame_nxt   = 1'b0;
        parity_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (s_prev && !s) begin
                    state_nxt = S_START;
                    tmr_nxt   = HALF_M1;
                end
            end
            S_START: begin
                if (tc) begin
                    if (s) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt   = S_DATA;
                        tmr_nxt     = FULL_M1;
                        bit_idx_nxt = '0;
                    end
                end
            end
            S_DATA: begin
                if (tc) begin
                    shreg_nxt = {s, shreg[DATA_BITS-1:1]};
                    tmr_nxt   = FULL_M1;
                    if (bit_idx == LAST_BIT)
                        state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                    else
                        bit_idx_nxt = bit_idx + BW'(1);
                end
            end
            S_PARITY: begin
                if (tc) begin
                    par_bit_nxt = s;
                    tmr_nxt     = FULL_M1;
                    state_nxt   = S_STOP;
                end
            end
            S_STOP: begin
                if (tc) begin
                    // framing error wins over a parity error on the same frame
                    if (!s) begin
                        frame_nxt = 1'b1;
                        state_nxt = S_BREAK;
                    end else begin
                        state_nxt = S_IDLE;
                        if (!par_ok)
                            parity_nxt = 1'b1;
                        else
                            push_req = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (s)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign full        = (count == LW'(FIFO_DEPTH));
    assign rx_valid    = (count != '0);
    assign pop         = rx_valid && rx_ready;
    assign do_push     = push_req && (!full || pop);
    assign overrun_nxt = push_req && full && !pop;
    assign fifo_level  = count;
    assign rx_byte     = rx_valid ? mem[rd_ptr] : last_head;

    always_ff @(posedge clk500kHz) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_head <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                last_head <= mem[rd_ptr];
            end
            if (do_push && !pop)
                count <= count + LW'(1);
            else if (pop && !do_push)
                count <= count - LW'(1);
        end
    end

    // storage needs no reset: every readable entry is written before rx_valid rises
    always_ff @(posedge clk500kHz) begin
        if (rst_n && do_push)
            mem[wr_ptr] <= shreg;
    end
endmodule

// File: tb/tb_midi_uart_rx_fifo.sv
// Bench for midi_uart_rx_fifo: one no-parity and one even-parity receiver, directed
// scenarios plus random frames scored against a frame-level reference model.
module tb_midi_uart_rx_fifo;
    localparam int CPB = 16;
    localparam int DB  = 8;
    localparam int STOP_EDGE = 3 + CPB / 2 + (DB + 1) * CPB;

    logic       clk500kHz = 1'b0;
    logic       rst_n;
    logic [1:0] rx_line;
    logic [1:0] ready;
    logic [7:0] byte0, byte1;
    logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1;
    logic [2:0] lvl0, lvl1;

    always #5 clk500kHz = ~clk500kHz;

    midi_uart_rx_fifo #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .PARITY(0), .FIFO_DEPTH(4)) dut0 (
        .clk500kHz(clk500kHz), .rst_n(rst_n), .rx_in(rx_line[0]), .rx_byte(byte0),
        .rx_valid(v0), .rx_ready(ready[0]), .frame_err(fe0), .parity_err(pe0),
        .overrun(ov0), .fifo_level(lvl0));

    midi_uart_rx_fifo #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .PARITY(1), .FIFO_DEPTH(4)) dut1 (
        .clk500kHz(clk500kHz), .rst_n(rst_n), .rx_in(rx_line[1]), .rx_byte(byte1),
        .rx_valid(v1), .rx_ready(ready[1]), .frame_err(fe1), .parity_err(pe1),
        .overrun(ov1), .fifo_level(lvl1));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fe[2], n_pe[2], n_ov[2], n_multi;
    int e_fe[2], e_pe[2], e_ov[2];
    logic [7:0] got0[$], got1[$], exp0[$], exp1[$];

    // monitor: inputs change on negedge, so values seen 1 unit later hold through the next posedge
    always @(negedge clk500kHz) begin
        #1;
        if (rst_n) begin
            n_fe[0] += int'(fe0); n_pe[0] += int'(pe0); n_ov[0] += int'(ov0);
            n_fe[1] += int'(fe1); n_pe[1] += int'(pe1); n_ov[1] += int'(ov1);
            if (int'(fe0) + int'(pe0) + int'(ov0) > 1) n_multi++;
            if (int'(fe1) + int'(pe1) + int'(ov1) > 1) n_multi++;
            if (v0 && ready[0]) got0.push_back(byte0);
            if (v1 && ready[1]) got1.push_back(byte1);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk500kHz);
    endtask

    task automatic send_bit(input int w, input logic v);
        rx_line[w] = v;
        idle(CPB);
    endtask

    task automatic send_frame(input int w, input logic [7:0] d, input bit bad_par,
                              input bit bad_stop, input int extra_low);
        send_bit(w, 1'b0);
        for (int i = 0; i < DB; i++) send_bit(w, d[i]);
        if (w == 1) send_bit(w, (^d) ^ bad_par);
        if (bad_stop) begin
            send_bit(w, 1'b0);
            idle(extra_low * CPB);
            rx_line[w] = 1'b1;
            idle(2);
        end else begin
            send_bit(w, 1'b1);
        end
    endtask

    task automatic send_glitch(input int w, input int len);
        rx_line[w] = 1'b0;
        idle(len);
        rx_line[w] = 1'b1;
        idle(CPB + 4);
    endtask

    // reference: a low stop bit is a framing error regardless of parity; else parity decides
    task automatic run_frame(input int w, input logic [7:0] d, input bit bad_par, input bit bad_stop);
        int extra;
        extra = bad_stop ? int'($urandom_range(0, 2)) : 0;
        send_frame(w, d, bad_par, bad_stop, extra);
        if (bad_stop) e_fe[w]++;
        else if (w == 1 && bad_par) e_pe[w]++;
        else if (w == 0) exp0.push_back(d);
        else exp1.push_back(d);
    endtask

    task automatic verify(input string tag, input int w);
        check({tag, "_frame_err"}, n_fe[w], e_fe[w]);
        check({tag, "_parity_err"}, n_pe[w], e_pe[w]);
        check({tag, "_overrun"}, n_ov[w], e_ov[w]);
        check({tag, "_exclusive"}, n_multi, 0);
        if (w == 0) begin
            check({tag, "_count"}, got0.size(), exp0.size());
            for (int i = 0; i < exp0.size() && i < got0.size(); i++)
                check($sformatf("%s_byte%0d", tag, i), int'(got0[i]), int'(exp0[i]));
            got0.delete(); exp0.delete();
        end else begin
            check({tag, "_count"}, got1.size(), exp1.size());
            for (int i = 0; i < exp1.size() && i < got1.size(); i++)
                check($sformatf("%s_byte%0d", tag, i), int'(got1[i]), int'(exp1[i]));
            got1.delete(); exp1.delete();
        end
        n_fe[w] = 0; n_pe[w] = 0; n_ov[w] = 0; n_multi = 0;
        e_fe[w] = 0; e_pe[w] = 0; e_ov[w] = 0;
    endtask

    initial begin
        int kind, gap;
        logic [7:0] d;
        for (int w = 0; w < 2; w++) begin
            n_fe[w] = 0; n_pe[w] = 0; n_ov[w] = 0; e_fe[w] = 0; e_pe[w] = 0; e_ov[w] = 0;
        end
        n_multi = 0;
        rst_n   = 1'b0;
        rx_line = 2'b11;
        ready   = 2'b00;
        idle(3);
        check("rst_valid0", int'(v0), 0);
        check("rst_byte0", int'(byte0), 0);
        check("rst_level0", int'(lvl0), 0);
        check("rst_errs0", int'({fe0, pe0, ov0}), 0);
        check("rst_valid1", int'(v1), 0);
        check("rst_level1", int'(lvl1), 0);
        rst_n = 1'b1;
        idle(4);

        ready = 2'b11;
        run_frame(0, 8'h90, 1'b0, 1'b0);
        idle(40);
        verify("t1", 0);

        send_glitch(0, 6);
        check("t2_level", int'(lvl0), 0);
        run_frame(0, 8'h5a, 1'b0, 1'b0);
        idle(40);
        verify("t2", 0);

        send_frame(0, 8'h45, 1'b0, 1'b1, 2);
        e_fe[0]++;
        idle(20);
        run_frame(0, 8'hc3, 1'b0, 1'b0);
        idle(40);
        verify("t3", 0);

        ready[1] = 1'b0;
        send_frame(1, 8'h03, 1'b1, 1'b0, 0);
        e_pe[1]++;
        idle(20);
        check("t4_level_bad", int'(lvl1), 0);
        send_frame(1, 8'h03, 1'b0, 1'b0, 0);
        idle(20);
        check("t4_level_good", int'(lvl1), 1);
        exp1.push_back(8'h03);
        ready[1] = 1'b1;
        idle(10);
        verify("t4", 1);

        ready[0] = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(0, 8'(k), 1'b0, 1'b0, 0);
        for (int k = 1; k <= 4; k++) exp0.push_back(8'(k));
        e_ov[0] = 1;
        idle(10);
        check("t5_level_full", int'(lvl0), 4);
        ready[0] = 1'b1;
        idle(20);
        check("t5_level_drained", int'(lvl0), 0);
        verify("t5", 0);

        ready[0] = 1'b0;
        fork
            for (int k = 1; k <= 5; k++) send_frame(0, 8'(k), 1'b0, 1'b0, 0);
            begin
                idle(4 * (DB + 2) * CPB + STOP_EDGE - 1);
                ready[0] = 1'b1;
                idle(1);
                ready[0] = 1'b0;
            end
        join
        for (int k = 1; k <= 5; k++) exp0.push_back(8'(k));
        idle(10);
        check("t6_level_full", int'(lvl0), 4);
        ready[0] = 1'b1;
        idle(20);
        verify("t6", 0);

        ready[0] = 1'b0;
        run_frame(0, 8'ha5, 1'b0, 1'b0);
        run_frame(0, 8'h3c, 1'b0, 1'b0);
        idle(10);
        check("t6r_level_pre", int'(lvl0), 2);
        rx_line[0] = 1'b0;
        idle(4 * CPB);
        rst_n = 1'b0;
        rx_line[0] = 1'b1;
        idle(3);
        check("t6r_level_rst", int'(lvl0), 0);
        check("t6r_valid_rst", int'(v0), 0);
        rst_n = 1'b1;
        exp0.delete();
        idle(5);
        ready[0] = 1'b1;
        run_frame(0, 8'h7e, 1'b0, 1'b0);
        idle(40);
        verify("t6r", 0);

        ready = 2'b11;
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 16; k++) begin
                kind = int'($urandom_range(0, 4));
                d    = 8'($urandom);
                case (kind)
                    0, 1: run_frame(w, d, 1'b0, 1'b0);
                    2:    run_frame(w, d, 1'b1, 1'b0);
                    3:    run_frame(w, d, 1'($urandom), 1'b1);
                    default: send_glitch(w, int'($urandom_range(1, 7)));
                endcase
                gap = int'($urandom_range(0, 20));
                idle(gap);
            end
            idle(40);
            verify(w == 0 ? "rand0" : "rand1", w);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
